// File: rtl/fifo_axis_reader.sv
// Read-side consumer for a standard (non-FWFT) FIFO, presented as an AXI-Stream master
// through a 2-entry skid buffer. Optional tlast generation: define FIFO_AXIS_READER_TLAST_EN.
module fifo_axis_reader #(
    parameter int unsigned BYTE_WIDTH   = 1,
    parameter int unsigned PACKET_BEATS = 16
) (
    input  logic                    rd_clk,
    input  logic                    rd_rstn,
    output logic                    fifo_rd_en,
    input  logic                    fifo_rd_empty,
    input  logic [BYTE_WIDTH*8-1:0] fifo_rd_data,
    output logic [BYTE_WIDTH*8-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);

    localparam int unsigned DW = BYTE_WIDTH * 8;

    if (BYTE_WIDTH < 1) begin : g_bad_byte_width
        $error("BYTE_WIDTH must be >= 1");
    end
    if (PACKET_BEATS < 1) begin : g_bad_packet_beats
        $error("PACKET_BEATS must be >= 1");
    end

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StHalf  = 2'd1,
        StFull  = 2'd2
    } buf_state_e;

    buf_state_e    state_q, state_d;
    logic          inflight_q;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          push;
    logic          pop;
    logic [2:0]    occupancy;

    assign push = inflight_q;
    assign pop  = m_axis_tvalid & m_axis_tready;

    // Slots committed after this edge; a read is only issued if its word is sure to fit.
    assign occupancy  = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = rd_rstn & ~fifo_rd_empty & (occupancy <= 3'd1);

    assign m_axis_tvalid = (state_q != StEmpty);
    assign m_axis_tdata  = head_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    head_d  = fifo_rd_data;
                    state_d = StHalf;
                end
            end
            StHalf: begin
                case ({push, pop})
                    2'b10: begin
                        tail_d  = fifo_rd_data;
                        state_d = StFull;
                    end
                    2'b01:   state_d = StEmpty;
                    2'b11:   head_d  = fifo_rd_data;
                    default: state_d = StHalf;
                endcase
            end
            StFull: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = fifo_rd_data;
                    end else begin
                        state_d = StHalf;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            state_q    <= StEmpty;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

`ifdef FIFO_AXIS_READER_TLAST_EN
    localparam int unsigned CntW = (PACKET_BEATS > 1) ? $clog2(PACKET_BEATS) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(PACKET_BEATS - 1);

    logic [CntW-1:0] beat_q, beat_d;

    always_comb begin
        beat_d = beat_q;
        if (pop) begin
            beat_d = (beat_q == LastBeat) ? '0 : beat_q + CntW'(1);
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign m_axis_tlast = m_axis_tvalid & (beat_q == LastBeat);
`else
    assign m_axis_tlast = 1'b0;
`endif

    a_no_overfill: assert property (@(posedge rd_clk) disable iff (!rd_rstn)
        !(state_q == StFull && push && !pop));

    a_legal_state: assert property (@(posedge rd_clk) disable iff (!rd_rstn)
        state_q inside {StEmpty, StHalf, StFull});

    a_tdata_stable: assert property (@(posedge rd_clk) disable iff (!rd_rstn)
        (m_axis_tvalid && !m_axis_tready) |=> (m_axis_tvalid && $stable(m_axis_tdata)));

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed bench for fifo_axis_reader: behavioural FIFO model, stream monitor and
// hand-computed expectations. tlast expectations follow FIFO_AXIS_READER_TLAST_EN.
module tb_fifo_axis_reader;

    localparam int unsigned PB = 4;

    logic       rd_clk = 1'b0;
    logic       rd_rstn;
    logic       fifo_rd_en;
    logic       fifo_rd_empty;
    logic [7:0] fifo_rd_data = 8'h00;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;

    fifo_axis_reader #(
        .BYTE_WIDTH  (1),
        .PACKET_BEATS(PB)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rstn      (rd_rstn),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_data (fifo_rd_data),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast)
    );

    always #5 rd_clk = ~rd_clk;

    // Standard-mode FIFO: data appears one clock after an accepted read.
    logic [7:0] mem [0:127];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign fifo_rd_empty = (rd_ptr == wr_ptr);

    always @(posedge rd_clk) begin
        if (fifo_rd_en && !fifo_rd_empty) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    logic [7:0] beat_data [$];
    logic       beat_last [$];
    int         reads_total = 0;

    always @(negedge rd_clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            beat_data.push_back(m_axis_tdata);
            beat_last.push_back(m_axis_tlast);
        end
        if (fifo_rd_en && !fifo_rd_empty) reads_total++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic check_beats(input string tag, input int base, input int idx,
                               input logic [7:0] exp);
        if (base + idx < beat_data.size()) check_eq(tag, 32'(beat_data[base + idx]), 32'(exp));
        else check_eq({tag, " missing"}, 32'(beat_data.size() - base), 32'(idx + 1));
    endtask

    function automatic logic exp_last(input int k);
`ifdef FIFO_AXIS_READER_TLAST_EN
        return ((k % PB) == PB - 1);
`else
        return 1'b0 & (k >= 0);
`endif
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rbase;
        int first_rd;
        int first_vld;
        int stable_bad;
        logic [7:0] tmp8;
        logic [15:0] pat;

        rd_rstn       = 1'b0;
        m_axis_tready = 1'b0;

        // Reset state, with words already waiting in the FIFO.
        tick(3);
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        #1;
        check_eq("reset rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("reset tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("reset tdata", 32'(m_axis_tdata), 32'd0);
        check_eq("reset tlast", 32'(m_axis_tlast), 32'd0);

        // Continuous tready: latency 2, four back-to-back beats.
        @(posedge rd_clk); #2;
        rd_rstn       = 1'b1;
        m_axis_tready = 1'b1;
        first_rd  = -1;
        first_vld = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge rd_clk);
            if (fifo_rd_en && first_rd < 0) first_rd = c;
            if (m_axis_tvalid && first_vld < 0) first_vld = c;
        end
        check_eq("t1 first rd_en cycle", 32'(first_rd), 32'd0);
        check_eq("t1 read-to-valid latency", 32'(first_vld - first_rd), 32'd2);
        check_eq("t1 beat count", 32'(beat_data.size()), 32'd4);
        check_beats("t1 beat0", 0, 0, 8'h11);
        check_beats("t1 beat1", 0, 1, 8'h22);
        check_beats("t1 beat2", 0, 2, 8'h33);
        check_beats("t1 beat3", 0, 3, 8'h44);
        check_eq("t1 reads", 32'(reads_total), 32'd4);
        check_eq("t1 tvalid idle", 32'(m_axis_tvalid), 32'd0);

        // Backpressure: only two reads issued while stalled, head held stable.
        @(posedge rd_clk); #1;
        base  = beat_data.size();
        rbase = reads_total;
        m_axis_tready = 1'b0;
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        stable_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge rd_clk);
            if (m_axis_tvalid && m_axis_tdata != 8'h11) stable_bad++;
        end
        check_eq("t2 reads while stalled", 32'(reads_total - rbase), 32'd2);
        check_eq("t2 rd_en stalled", 32'(fifo_rd_en), 32'd0);
        check_eq("t2 tvalid stalled", 32'(m_axis_tvalid), 32'd1);
        check_eq("t2 tdata stalled", 32'(m_axis_tdata), 32'h11);
        check_eq("t2 tdata unstable cycles", 32'(stable_bad), 32'd0);
        @(posedge rd_clk); #1;
        m_axis_tready = 1'b1;
        tick(12);
        check_eq("t2 beat count", 32'(beat_data.size() - base), 32'd4);
        check_beats("t2 beat0", base, 0, 8'h11);
        check_beats("t2 beat1", base, 1, 8'h22);
        check_beats("t2 beat2", base, 2, 8'h33);
        check_beats("t2 beat3", base, 3, 8'h44);
        check_eq("t2 reads", 32'(reads_total - rbase), 32'd4);

        // tready toggling every cycle, 32 incrementing words.
        base = beat_data.size();
        for (int i = 0; i < 32; i++) load(8'(i));
        for (int c = 0; c < 200 && (beat_data.size() - base) < 32; c++) begin
            @(posedge rd_clk); #1;
            m_axis_tready = ~m_axis_tready;
        end
        check_eq("t3 beat count", 32'(beat_data.size() - base), 32'd32);
        for (int i = 0; i < 32; i++) begin
            tmp8 = 8'(i);
            check_beats($sformatf("t3 beat%0d", i), base, i, tmp8);
        end

        // Empty FIFO: nothing read, nothing presented.
        @(posedge rd_clk); #1;
        m_axis_tready = 1'b1;
        tick(2);
        rbase = reads_total;
        tick(10);
        check_eq("t4 reads", 32'(reads_total - rbase), 32'd0);
        check_eq("t4 rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("t4 tvalid", 32'(m_axis_tvalid), 32'd0);

        // Reset with a full buffer: outputs clear without a clock edge.
        m_axis_tready = 1'b0;
        rbase = reads_total;
        load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4);
        tick(6);
        check_eq("t5 reads before reset", 32'(reads_total - rbase), 32'd2);
        check_eq("t5 tvalid before reset", 32'(m_axis_tvalid), 32'd1);
        #2;
        rd_rstn = 1'b0;
        #1;
        check_eq("t5 async tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("t5 async tdata", 32'(m_axis_tdata), 32'd0);
        check_eq("t5 async rd_en", 32'(fifo_rd_en), 32'd0);
        tick(2);
        base = beat_data.size();
        rd_rstn       = 1'b1;
        m_axis_tready = 1'b1;
        tick(8);
        check_eq("t5 beat count", 32'(beat_data.size() - base), 32'd2);
        check_beats("t5 beat0", base, 0, 8'hA3);
        check_beats("t5 beat1", base, 1, 8'hA4);

        // Packet boundaries across stalls, beat counter restarted by reset.
        @(posedge rd_clk); #1;
        rd_rstn = 1'b0;
        #1;
        rd_rstn = 1'b1;
        base = beat_data.size();
        for (int i = 0; i < 8; i++) load(8'h80 + 8'(i));
        pat = 16'b1011_0010_1101_0110;
        for (int c = 0; c < 100 && (beat_data.size() - base) < 8; c++) begin
            m_axis_tready = pat[c % 16];
            @(posedge rd_clk); #1;
        end
        check_eq("t6 beat count", 32'(beat_data.size() - base), 32'd8);
        for (int k = 0; k < 8; k++) begin
            tmp8 = 8'h80 + 8'(k);
            check_beats($sformatf("t6 beat%0d", k), base, k, tmp8);
            if (base + k < beat_last.size())
                check_eq($sformatf("t6 tlast%0d", k), 32'(beat_last[base + k]),
                         32'(exp_last(k)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
